posit_encode_es2: RTL and testbench
===================================

// Module: posit_encode_es2
// PURPOSE
//  Back end of the posit es2 arithmetic path. Takes the raw sum from the adder: sign, signed scale,
//  hidden-bit-stripped fraction, inf, zero and a truncated/sticky flag. Encodes it into a packed
//  posit<NBITS,2> word with round-to-nearest-even (RNE). It is a 3-stage pipeline with a
//  start/in_ready input handshake and a done/out_ready output handshake. It sits between the
//  raw adder (or the multiplier) and the result writeback.
// PARAMETERS
//  NBITS    32  packed posit width
//  SCALE_W   8  signed scale width (two's complement)
//  FRAC_W   30  raw fraction width; MSB is the first bit after the hidden bit
// PORTS
//  clk           in   1                    rising-edge clock
//  reset_n       in   1                    asynchronous reset, active low
//  start         in   1                    raw input is valid
//  in_ready      out  1                    block accepts input this cycle
//  in_sum        in   1+SCALE_W+FRAC_W+2   {sgn, scale, fraction, inf, zero}; defaults [40],[39:32],[31:2],[1],[0]
//  in_truncated  in   1                    upstream dropped nonzero bits (sticky)
//  result        out  NBITS                packed posit
//  done          out  1                    result is valid
//  out_ready     in   1                    consumer accepts result
// BEHAVIOUR
//  Clock and reset
//  - Reset is asynchronous on the falling edge of reset_n.
//  - Reset clears all stage valids; done=0, result=0, in_ready=1.
//  - Reset mid-operation discards every in-flight item. Nothing is emitted after release until a new start.
//  Handshake
//  - Transfer in on start&in_ready. Transfer out on done&out_ready.
//  - Global stall: in_ready = out_ready | ~done. While stalled, every stage holds.
//  - result is stable while done&~out_ready.
//  - Latency is exactly 3 cycles from accept to done when there is no stall.
//  - Throughput is 1 per cycle. Bubbles (start=0) propagate as invalid slots.
//  - start=X is treated as 0.
//  Stage 1: decode and clamp
//  - inf=1 gives NaR = 1 followed by zeros (0x80000000). inf has priority over zero.
//  - zero=1 gives 0x00000000.
//  - k = scale>>>2 (arithmetic shift); e = scale[1:0].
//  - smax = 4*(NBITS-2) = 120.
//  - scale >  smax saturates to maxpos, 0x7FFFFFFF.
//  - scale < -smax saturates to minpos, 0x00000001. Nonzero values never round to 0.
//  Stage 2: assemble and shift
//  - Regime for k>=0 is (k+1) ones then a 0. Regime for k<0 is (-k) zeros then a 1.
//  - Build {regime, e[1:0], fraction} and right-align it to NBITS-1 magnitude bits.
//  - Capture guard = first dropped bit.
//  - sticky = OR(remaining dropped bits) | in_truncated.
//  Stage 3: round and sign
//  - RNE: increment when guard&(lsb|sticky).
//  - An increment that would reach 0x80000000 saturates to 0x7FFFFFFF.
//  - A rounded magnitude of 0 becomes 0x00000001.
//  - sgn=1 gives the two's complement of the full NBITS word.
//  - inf and zero bypass rounding. The sign is ignored for zero and NaR.
// TESTING
//  1. scale=0, frac=0, sgn=0 -> 0x40000000; same with sgn=1 -> 0xC0000000.
//  2. scale=1 -> 0x48000000; scale=-1 -> 0x38000000; scale=-4 -> 0x20000000.
//  3. RNE, scale=0:
//     - frac=30'h4 -> 0x40000000 (tie, even)
//     - frac=30'hC -> 0x40000002 (tie, odd up)
//     - frac=30'h4 with in_truncated=1 -> 0x40000001
//  4. Saturation: scale=127 -> 0x7FFFFFFF; scale=-128 -> 0x00000001.
//     Specials: inf=1&zero=1 -> 0x80000000; zero=1 -> 0x00000000.
//  5. Back-to-back inputs (start held) with out_ready=0 for 5 cycles:
//     - in_ready=0 while stalled; no item lost or duplicated
//     - results emerge in order, result stable while stalled
//  6. Assert reset_n low with 3 items in flight:
//     - done=0 and result=0 immediately
//     - after release, no stale done until a new start, then done 3 cycles later

Source files
------------

// File: rtl/posit_encode_es2_if.sv
// Handshake bundle for the posit es2 encoder.
//   start        : raw input valid (master -> slave)
//   in_ready     : encoder accepts input this cycle (slave -> master)
//   in_sum       : {sgn, scale, fraction, inf, zero} raw adder output
//   in_truncated : upstream dropped nonzero bits (sticky)
//   result       : packed posit<NBITS,2> word (slave -> master)
//   done         : result valid (slave -> master)
//   out_ready    : consumer accepts result (master -> slave)
interface posit_encode_es2_if #(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned SCALE_W = 8,
  parameter int unsigned FRAC_W  = 30
);
  localparam int unsigned IN_W = 1 + SCALE_W + FRAC_W + 2;

  logic              start;
  logic              in_ready;
  logic [IN_W-1:0]   in_sum;
  logic              in_truncated;
  logic [NBITS-1:0]  result;
  logic              done;
  logic              out_ready;

  modport master (
    output start, in_sum, in_truncated, out_ready,
    input  in_ready, result, done
  );

  modport slave (
    input  start, in_sum, in_truncated, out_ready,
    output in_ready, result, done
  );
endinterface

// File: rtl/posit_encode_es2.sv
// Posit<NBITS,2> encoder: 3-stage pipeline turning a raw {sgn, scale, fraction,
// inf, zero} sum plus sticky flag into a packed posit with round-to-nearest-even.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/in_ready input handshake, done/out_ready output handshake
// Stage 1 decodes specials and clamps the scale, stage 2 builds and aligns the
// regime/exponent/fraction string, stage 3 rounds and applies the sign.
module posit_encode_es2 #(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned SCALE_W = 8,
  parameter int unsigned FRAC_W  = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  posit_encode_es2_if.slave bus
);
  localparam int unsigned MAG_W = NBITS - 1;
  localparam int unsigned IN_W  = 1 + SCALE_W + FRAC_W + 2;
  localparam int unsigned PAD_W = NBITS - 2;
  localparam int unsigned W     = 4 + FRAC_W + PAD_W;
  localparam int unsigned SMAX  = 4 * (NBITS - 2);

  localparam logic signed [SCALE_W-1:0] SMAX_S = SCALE_W'(SMAX);
  localparam logic [NBITS-1:0] NAR    = {1'b1, {MAG_W{1'b0}}};
  localparam logic [NBITS-1:0] MAXPOS = {1'b0, {MAG_W{1'b1}}};
  localparam logic [NBITS-1:0] MINPOS = NBITS'(1);

  // Global stall: every stage advances together only when the output slot frees up
  logic w_adv;
  logic w_start;
  assign w_adv   = bus.out_ready | ~bus.done;
  assign w_start = (bus.start === 1'b1);

  // ---------------- Stage 1: decode and clamp ----------------
  logic                      w1_sgn;
  logic signed [SCALE_W-1:0] w1_scale;
  logic signed [SCALE_W-1:0] w1_k;
  logic                      w1_k_neg;
  logic [SCALE_W-1:0]        w1_shamt;
  logic [FRAC_W-1:0]         w1_frac;
  logic                      w1_byp;
  logic                      w1_sgn_ok;
  logic [NBITS-1:0]          w1_byp_word;

  always_comb begin
    w1_sgn      = bus.in_sum[IN_W-1];
    w1_scale    = bus.in_sum[IN_W-2 -: SCALE_W];
    w1_frac     = bus.in_sum[FRAC_W+1:2];
    w1_k        = w1_scale >>> 2;
    w1_k_neg    = w1_k[SCALE_W-1];
    // k>=0 shifts a "10" seed right by k; k<0 shifts a "01" seed by -k-1 == ~k
    w1_shamt    = w1_k_neg ? ~w1_k : w1_k;
    w1_byp      = 1'b0;
    w1_sgn_ok   = 1'b0;
    w1_byp_word = '0;
    if (bus.in_sum[1]) begin
      w1_byp      = 1'b1;
      w1_byp_word = NAR;
    end else if (bus.in_sum[0]) begin
      w1_byp      = 1'b1;
    end else if (w1_scale > SMAX_S) begin
      w1_byp      = 1'b1;
      w1_sgn_ok   = 1'b1;
      w1_byp_word = MAXPOS;
    end else if (w1_scale < -SMAX_S) begin
      w1_byp      = 1'b1;
      w1_sgn_ok   = 1'b1;
      w1_byp_word = MINPOS;
    end
  end

  logic               r1_valid, r1_sgn, r1_byp, r1_sgn_ok, r1_k_neg, r1_trunc;
  logic [NBITS-1:0]   r1_byp_word;
  logic [SCALE_W-1:0] r1_shamt;
  logic [1:0]         r1_e;
  logic [FRAC_W-1:0]  r1_frac;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_valid    <= 1'b0;
      r1_sgn      <= 1'b0;
      r1_byp      <= 1'b0;
      r1_sgn_ok   <= 1'b0;
      r1_k_neg    <= 1'b0;
      r1_trunc    <= 1'b0;
      r1_byp_word <= '0;
      r1_shamt    <= '0;
      r1_e        <= '0;
      r1_frac     <= '0;
    end else if (w_adv) begin
      r1_valid    <= w_start;
      r1_sgn      <= w1_sgn;
      r1_byp      <= w1_byp;
      r1_sgn_ok   <= w1_sgn_ok;
      r1_k_neg    <= w1_k_neg;
      r1_trunc    <= bus.in_truncated;
      r1_byp_word <= w1_byp_word;
      r1_shamt    <= w1_shamt;
      r1_e        <= w1_scale[1:0];
      r1_frac     <= w1_frac;
    end
  end

  // ---------------- Stage 2: assemble and shift ----------------
  // Arithmetic shift of the seed replicates the leading regime bit, so one
  // shifter produces both the run of ones and the run of zeros.
  logic [W-1:0] w2_seed;
  logic [W-1:0] w2_sh;

  always_comb begin
    w2_seed = {(r1_k_neg ? 2'b01 : 2'b10), r1_e, r1_frac, {PAD_W{1'b0}}};
    w2_sh   = $unsigned($signed(w2_seed) >>> r1_shamt);
  end

  logic             r2_valid, r2_sgn, r2_byp, r2_sgn_ok, r2_guard, r2_sticky;
  logic [NBITS-1:0] r2_byp_word;
  logic [MAG_W-1:0] r2_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r2_valid    <= 1'b0;
      r2_sgn      <= 1'b0;
      r2_byp      <= 1'b0;
      r2_sgn_ok   <= 1'b0;
      r2_guard    <= 1'b0;
      r2_sticky   <= 1'b0;
      r2_byp_word <= '0;
      r2_mag      <= '0;
    end else if (w_adv) begin
      r2_valid    <= r1_valid;
      r2_sgn      <= r1_sgn;
      r2_byp      <= r1_byp;
      r2_sgn_ok   <= r1_sgn_ok;
      r2_byp_word <= r1_byp_word;
      r2_mag      <= w2_sh[W-1 -: MAG_W];
      r2_guard    <= w2_sh[W-NBITS];
      r2_sticky   <= (|w2_sh[W-NBITS-1:0]) | r1_trunc;
    end
  end

  // ---------------- Stage 3: round and sign ----------------
  logic             w3_inc;
  logic             w3_neg;
  logic [NBITS-1:0] w3_rnd;
  logic [NBITS-1:0] w3_mag;
  logic [NBITS-1:0] w3_word;

  always_comb begin
    w3_inc = r2_guard & (r2_mag[0] | r2_sticky);
    w3_rnd = {1'b0, r2_mag} + NBITS'(w3_inc);
    w3_mag = w3_rnd;
    // Never round into NaR, never round a nonzero value to zero
    if (w3_rnd[NBITS-1]) begin
      w3_mag = MAXPOS;
    end else if (w3_rnd == '0) begin
      w3_mag = MINPOS;
    end
    if (r2_byp) begin
      w3_mag = r2_byp_word;
    end
    w3_neg  = r2_sgn & (~r2_byp | r2_sgn_ok);
    w3_word = w3_neg ? (~w3_mag + NBITS'(1)) : w3_mag;
  end

  logic             r3_valid;
  logic [NBITS-1:0] r3_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r3_valid  <= 1'b0;
      r3_result <= '0;
    end else if (w_adv) begin
      r3_valid  <= r2_valid;
      r3_result <= w3_word;
    end
  end

  assign bus.in_ready = w_adv;
  assign bus.done     = r3_valid;
  assign bus.result   = r3_result;
endmodule

// File: tb/tb_posit_encode_es2.sv
// Self-checking bench for posit_encode_es2: table vectors, random vectors checked
// against a bit-serial reference encoder, a back-pressure run and a mid-flight reset.
module tb_posit_encode_es2;
  localparam int unsigned NBITS   = 32;
  localparam int unsigned SCALE_W = 8;
  localparam int unsigned FRAC_W  = 30;

  typedef struct {
    bit                sgn;
    int                scale;
    logic [FRAC_W-1:0] frac;
    bit                inf;
    bit                zero;
    bit                trunc;
    logic [NBITS-1:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  posit_encode_es2_if #(.NBITS(NBITS), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) bus ();

  posit_encode_es2 #(.NBITS(NBITS), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [NBITS-1:0] sb_q[$];
  int               acc_q[$];
  logic [NBITS-1:0] cur_exp;
  bit lat_chk  = 1'b0;
  bit rand_rdy = 1'b0;
  bit rdy_val  = 1'b1;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference encoder: writes the posit bit string one bit at a time
  function automatic logic [NBITS-1:0] ref_enc(input vec_t v);
    logic [127:0] bits;
    logic [1:0]   eb;
    logic [30:0]  mag;
    logic [31:0]  m;
    logic         g, s;
    int           n, k, e;
    if (v.inf)  return 32'h8000_0000;
    if (v.zero) return 32'h0;
    if (v.scale > 120)       m = 32'h7FFF_FFFF;
    else if (v.scale < -120) m = 32'h0000_0001;
    else begin
      e    = v.scale & 3;
      k    = (v.scale - e) / 4;
      eb   = 2'(e);
      bits = '0;
      n    = 0;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin
          bits[127-n] = 1'b1;
          n++;
        end
        n++;
      end else begin
        n = -k;
        bits[127-n] = 1'b1;
        n++;
      end
      bits[127-n] = eb[1];
      bits[126-n] = eb[0];
      n += 2;
      for (int i = FRAC_W - 1; i >= 0; i--) begin
        bits[127-n] = v.frac[i];
        n++;
      end
      mag = bits[127:97];
      g   = bits[96];
      s   = (|bits[95:0]) | v.trunc;
      m   = {1'b0, mag} + 32'(g & (mag[0] | s));
      if (m[31]) m = 32'h7FFF_FFFF;
      if (m == 32'h0) m = 32'h1;
    end
    if (v.sgn) m = -m;
    return m;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.sgn   = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 0) v.scale = int'($urandom_range(0, 24)) - 12;
    else                           v.scale = int'($urandom_range(0, 255)) - 128;
    v.frac  = FRAC_W'($urandom);
    v.inf   = ($urandom_range(0, 15) == 0);
    v.zero  = ($urandom_range(0, 15) == 0);
    v.trunc = 1'($urandom_range(0, 1));
    v.exp   = ref_enc(v);
    return v;
  endfunction

  // Consumer back-pressure, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Scoreboard: push on accept, compare while done, pop on transfer out
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      if (bus.start === 1'b1 && bus.in_ready === 1'b1) begin
        sb_q.push_back(cur_exp);
        acc_q.push_back(cyc);
      end
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'(bus.done), 32'h0);
        end else begin
          chk("result", bus.result, sb_q[0]);
          if (bus.out_ready === 1'b1) begin
            if (lat_chk) chk("latency", 32'(cyc - acc_q[0]), 32'd3);
            void'(sb_q.pop_front());
            void'(acc_q.pop_front());
          end else begin
            chk("in_ready_stall", 32'(bus.in_ready), 32'h0);
          end
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    bit acc;
    acc = 1'b0;
    bus.in_sum       = {v.sgn, SCALE_W'(v.scale), v.frac, v.inf, v.zero};
    bus.in_truncated = v.trunc;
    cur_exp          = v.exp;
    bus.start        = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = (bus.in_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.in_sum       = '0;
    bus.in_truncated = 1'b0;
    cur_exp          = '0;

    //           sgn  scale frac          inf   zero  trunc expected
    tbl[0]  = '{1'b0,    0, 30'h0,        1'b0, 1'b0, 1'b0, 32'h4000_0000};
    tbl[1]  = '{1'b1,    0, 30'h0,        1'b0, 1'b0, 1'b0, 32'hC000_0000};
    tbl[2]  = '{1'b0,    1, 30'h0,        1'b0, 1'b0, 1'b0, 32'h4800_0000};
    tbl[3]  = '{1'b0,   -1, 30'h0,        1'b0, 1'b0, 1'b0, 32'h3800_0000};
    tbl[4]  = '{1'b0,   -4, 30'h0,        1'b0, 1'b0, 1'b0, 32'h2000_0000};
    tbl[5]  = '{1'b0,    0, 30'h4,        1'b0, 1'b0, 1'b0, 32'h4000_0000};
    tbl[6]  = '{1'b0,    0, 30'hC,        1'b0, 1'b0, 1'b0, 32'h4000_0002};
    tbl[7]  = '{1'b0,    0, 30'h4,        1'b0, 1'b0, 1'b1, 32'h4000_0001};
    tbl[8]  = '{1'b0,  127, 30'h0,        1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF};
    tbl[9]  = '{1'b0, -128, 30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0001};
    tbl[10] = '{1'b0,    0, 30'h0,        1'b1, 1'b1, 1'b0, 32'h8000_0000};
    tbl[11] = '{1'b0,    5, 30'h123,      1'b0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[12] = '{1'b1,    3, 30'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[13] = '{1'b1,    3, 30'h0,        1'b1, 1'b0, 1'b0, 32'h8000_0000};
    tbl[14] = '{1'b1,  127, 30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0001};
    tbl[15] = '{1'b0,  120, 30'h3FFFFFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF};
    tbl[16] = '{1'b0, -120, 30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0001};
    tbl[17] = '{1'b0, -118, 30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0002};
    tbl[18] = '{1'b0,    0, 30'h3FFFFFFF, 1'b0, 1'b0, 1'b0, 32'h4800_0000};

    // Reset state
    #1;
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table vectors streamed with the consumer always ready
    lat_chk = 1'b1;
    foreach (tbl[i]) drive(tbl[i]);
    idle(1);
    drain();

    // Random vectors with bubbles and random back-pressure
    lat_chk  = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(rand_vec());
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
    rand_rdy = 1'b0;
    rdy_val  = 1'b1;
    drain();

    // Start held back-to-back while the consumer stalls for several cycles
    rdy_val = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) drive(tbl[i]);
        bus.start = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        rdy_val = 1'b1;
      end
    join
    idle(1);
    drain();

    // Reset with three items in flight
    lat_chk = 1'b1;
    for (int i = 2; i < 5; i++) drive(tbl[i]);
    bus.start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_done", 32'(bus.done), 32'h0);
    chk("midrst_result", bus.result, 32'h0);
    sb_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stale_done", 32'(bus.done), 32'h0);
    end
    @(posedge clk);
    #1;
    drive(tbl[6]);
    bus.start = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
